// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared constants and types for the 1x3 router output FIFO.
//   DATA_W       byte width of the router stream
//   FIFO_DEPTH   entries per output FIFO (power of two)
//   FIFO_ADDR_W  log2(FIFO_DEPTH); FIFO pointers carry one extra wrap bit
//   HDR_LEN_*    payload-length field inside a header byte
//   HDR_ADDR_W   destination-address field width inside a header byte
//   PKT_CNT_W    width of the read-side packet byte counter
// ----------------------------------------------------------------------------
package router_pkg;

   localparam int DATA_W      = 8;
   localparam int FIFO_DEPTH  = 16;
   localparam int FIFO_ADDR_W = 4;
   localparam int HDR_LEN_MSB = 7;
   localparam int HDR_LEN_LSB = 2;
   localparam int HDR_ADDR_W  = 2;
   localparam int PKT_CNT_W   = 7;

   // One FIFO entry: header marker above the data byte.
   typedef struct packed {
      logic              hdr;
      logic [DATA_W-1:0] data;
   } fifo_word_t;

   // Bytes still to follow a header: payload length plus the parity byte.
   function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [DATA_W-1:0] hdr_byte);
      return PKT_CNT_W'(hdr_byte[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/router_fifo_if.sv
// ----------------------------------------------------------------------------
// router_fifo_if
// Bundle between the register stage / read port (master) and one output
// FIFO (slave).
//   soft_reset   sync flush request
//   write_enb    write request, lfd_state marks data_in as a header
//   read_enb     read request
//   data_in      byte from register stage
//   data_out     registered read byte
//   full/empty   occupancy flags
//   pkt_active   packet read in progress
//   fill_level   entry count (only with ROUTER_FIFO_OCCUPANCY_EN defined)
// ----------------------------------------------------------------------------
interface router_fifo_if;
   import router_pkg::*;

   logic              soft_reset;
   logic              write_enb;
   logic              read_enb;
   logic              lfd_state;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
   logic              pkt_active;
`ifdef ROUTER_FIFO_OCCUPANCY_EN
   logic [FIFO_ADDR_W:0] fill_level;
`endif

   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
`ifdef ROUTER_FIFO_OCCUPANCY_EN
      input  fill_level,
`endif
      input  data_out, full, empty, pkt_active
   );

   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
`ifdef ROUTER_FIFO_OCCUPANCY_EN
      output fill_level,
`endif
      output data_out, full, empty, pkt_active
   );

endinterface

// File: rtl/router_fifo_mem.sv
// ----------------------------------------------------------------------------
// router_fifo_mem
// (DATA_W+1) x DEPTH storage for one output FIFO. Synchronous write,
// asynchronous read by address; contents are never reset.
//   clock      rising-edge clock
//   wr_en_i    write strobe (already qualified by the FIFO)
//   wr_addr_i  write address
//   wr_word_i  {header marker, byte}
//   rd_addr_i  read address
//   rd_word_o  word at rd_addr_i
// ----------------------------------------------------------------------------
module router_fifo_mem
   import router_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clock,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  fifo_word_t        wr_word_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output fifo_word_t        rd_word_o
);

   fifo_word_t mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_word_i;
      end
   end

   assign rd_word_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_fifo.sv
// ----------------------------------------------------------------------------
// router_fifo
// Per-destination output FIFO of the 1x3 router. Stores header/payload/parity
// bytes with a header marker and, on the read side, counts the packet length
// so the reader sees exactly header + payload + parity before data_out idles
// back to zero.
//   clock    rising-edge clock
//   resetn   asynchronous active-low reset
//   fifo     router_fifo_if.slave: soft_reset, write_enb, read_enb,
//            lfd_state, data_in, data_out, full, empty, pkt_active
//            (+ fill_level when ROUTER_FIFO_OCCUPANCY_EN is defined)
// Optional feature macro: ROUTER_FIFO_OCCUPANCY_EN adds fill_level.
// ----------------------------------------------------------------------------
module router_fifo
   import router_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic         clock,
   input  logic         resetn,
   router_fifo_if.slave fifo
);

   logic [ADDR_W:0]    wr_ptr_q,   wr_ptr_d;
   logic [ADDR_W:0]    rd_ptr_q,   rd_ptr_d;
   logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [DATA_W-1:0]  data_out_q, data_out_d;

   logic       full_w;
   logic       empty_w;
   logic       wr_acc;
   logic       rd_acc;
   fifo_word_t wr_word;
   fifo_word_t rd_word;

   // Flags come from registered pointers only; the wrap bit tells a full
   // ring from an empty one when the index bits match.
   assign full_w  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign empty_w = (wr_ptr_q == rd_ptr_q);

   // soft_reset wins over both ports in the same cycle. A full FIFO refuses a
   // write even when a read frees an entry on the same edge.
   assign wr_acc = fifo.write_enb && !full_w  && !fifo.soft_reset;
   assign rd_acc = fifo.read_enb  && !empty_w && !fifo.soft_reset;

   assign wr_word.hdr  = fifo.lfd_state;
   assign wr_word.data = fifo.data_in;

   router_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
      .wr_word_i (wr_word),
      .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
      .rd_word_o (rd_word)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pkt_cnt_d  = pkt_cnt_q;
      data_out_d = data_out_q;

      if (fifo.soft_reset) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         pkt_cnt_d  = '0;
         data_out_d = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
         end

         if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(1);
            data_out_d = rd_word.data;
            if (rd_word.hdr) begin
               pkt_cnt_d = hdr_pkt_cnt(rd_word.data);
            end else if (pkt_cnt_q != '0) begin
               pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
            end
         end else if (pkt_cnt_q == '0) begin
            // Between packets the read port idles at zero.
            data_out_d = '0;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         data_out_q <= data_out_d;
      end
   end

   assign fifo.data_out   = data_out_q;
   assign fifo.full       = full_w;
   assign fifo.empty      = empty_w;
   assign fifo.pkt_active = (pkt_cnt_q != '0);

`ifdef ROUTER_FIFO_OCCUPANCY_EN
   // Modular difference of the wrap-bit pointers gives 0..DEPTH directly.
   assign fifo.fill_level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// ----------------------------------------------------------------------------
// tb_router_fifo
// Self-checking bench for router_fifo. A queue holds the words the FIFO is
// expected to contain; reads pop it to form the expected data_out.
// ----------------------------------------------------------------------------
module tb_router_fifo;
   import router_pkg::*;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   always #5 clock = ~clock;

   router_fifo_if fif ();

   router_fifo dut (
      .clock  (clock),
      .resetn (resetn),
      .fifo   (fif)
   );

   int total = 0;
   int bad   = 0;

   logic [8:0] model_q [$];
   logic [6:0] m_cnt  = '0;
   logic [7:0] m_dout = '0;

   task automatic model_clear();
      model_q.delete();
      m_cnt  = '0;
      m_dout = '0;
   endtask

   // One clock with the given inputs; the model advances by what the spec
   // says the FIFO accepts, judged from the model's own occupancy.
   task automatic cycle(input logic we, input logic re, input logic lfd,
                        input logic sr, input logic [7:0] din);
      logic [8:0] w;
      logic wr_ok, rd_ok;
      fif.write_enb  = we;
      fif.read_enb   = re;
      fif.lfd_state  = lfd;
      fif.soft_reset = sr;
      fif.data_in    = din;
      wr_ok = we && !sr && (model_q.size() < 16);
      rd_ok = re && !sr && (model_q.size() != 0);
      @(posedge clock);
      #1;
      if (sr) begin
         model_clear();
      end else begin
         if (rd_ok) begin
            w = model_q.pop_front();
            m_dout = w[7:0];
            if (w[8])                m_cnt = {1'b0, w[7:2]} + 7'd1;
            else if (m_cnt != 7'd0)  m_cnt = m_cnt - 7'd1;
         end else if (m_cnt == 7'd0) begin
            m_dout = '0;
         end
         if (wr_ok) model_q.push_back({lfd, din});
      end
      $display("txn t=%0t we=%0b re=%0b lfd=%0b sr=%0b din=%02h -> dout=%02h full=%0b empty=%0b act=%0b",
               $time, we, re, lfd, sr, din, fif.data_out, fif.full, fif.empty, fif.pkt_active);
      fif.write_enb  = 1'b0;
      fif.read_enb   = 1'b0;
      fif.lfd_state  = 1'b0;
      fif.soft_reset = 1'b0;
      fif.data_in    = '0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (fif.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", fif.empty); end
      total++; if (fif.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", fif.full); end
      total++; if (fif.data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %02h want 00", fif.data_out); end
      total++; if (fif.pkt_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %0b want 0", fif.pkt_active); end
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      model_clear();
   endtask

   task automatic test_async_reset_midstream();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1 + 8'(i));
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (fif.data_out !== 8'hA1) begin bad++; $display("FAIL midrst_first: got %02h want a1", fif.data_out); end
      #2;
      resetn = 1'b0;
      #1;
      total++; if (fif.empty !== 1'b1) begin bad++; $display("FAIL midrst_empty: got %0b want 1", fif.empty); end
      total++; if (fif.full !== 1'b0) begin bad++; $display("FAIL midrst_full: got %0b want 0", fif.full); end
      total++; if (fif.data_out !== 8'h00) begin bad++; $display("FAIL midrst_dout: got %02h want 00", fif.data_out); end
      model_clear();
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_full_wrap();
      logic [7:0] vals [16];
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 0; i < 16; i++) begin
            vals[i] = 8'($urandom_range(1, 255));
            cycle(1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
         end
         total++; if (fif.full !== 1'b1) begin bad++; $display("FAIL wrap_full rep%0d: got %0b want 1", rep, fif.full); end
         total++; if (fif.empty !== 1'b0) begin bad++; $display("FAIL wrap_notempty rep%0d: got %0b want 0", rep, fif.empty); end
         cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h5C);
         total++; if (fif.full !== 1'b1) begin bad++; $display("FAIL wrap_drop rep%0d: got %0b want 1", rep, fif.full); end
         for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            total++; if (fif.data_out !== vals[i]) begin bad++; $display("FAIL wrap_data rep%0d[%0d]: got %02h want %02h", rep, i, fif.data_out, vals[i]); end
         end
         total++; if (fif.empty !== 1'b1 || fif.full !== 1'b0) begin bad++; $display("FAIL wrap_drained rep%0d: got empty=%0b full=%0b want 1/0", rep, fif.empty, fif.full); end
      end
   endtask

   task automatic test_simul_rw_full();
      logic [7:0] vals [16];
      for (int i = 0; i < 16; i++) begin
         vals[i] = 8'h30 + 8'(i);
         cycle(1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
      total++; if (fif.data_out !== vals[0]) begin bad++; $display("FAIL simul_read: got %02h want %02h", fif.data_out, vals[0]); end
      total++; if (fif.full !== 1'b0) begin bad++; $display("FAIL simul_full: got %0b want 0", fif.full); end
      for (int i = 1; i < 16; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         total++; if (fif.data_out !== vals[i]) begin bad++; $display("FAIL simul_drain[%0d]: got %02h want %02h", i, fif.data_out, vals[i]); end
      end
      total++; if (fif.empty !== 1'b1) begin bad++; $display("FAIL simul_dropped: got empty=%0b want 1", fif.empty); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_packet();
      logic [7:0] pkt [5];
      logic [7:0] exp_b;
      pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, (i == 0), 1'b0, pkt[i]);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         exp_b = model_q.size() == 0 ? m_dout : m_dout;
         total++; if (fif.data_out !== pkt[i] || fif.data_out !== exp_b) begin bad++; $display("FAIL pkt_data[%0d]: got %02h want %02h", i, fif.data_out, pkt[i]); end
         total++; if (fif.pkt_active !== (i < 4)) begin bad++; $display("FAIL pkt_active[%0d]: got %0b want %0b", i, fif.pkt_active, (i < 4)); end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      total++; if (fif.data_out !== 8'h00 || fif.pkt_active !== 1'b0) begin bad++; $display("FAIL pkt_idle: got dout=%02h act=%0b want 00/0", fif.data_out, fif.pkt_active); end
      // Zero-length header: only the parity byte follows.
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h02);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (fif.data_out !== 8'h02 || fif.pkt_active !== 1'b1) begin bad++; $display("FAIL len0_hdr: got dout=%02h act=%0b want 02/1", fif.data_out, fif.pkt_active); end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (fif.data_out !== 8'h5A || fif.pkt_active !== 1'b0) begin bad++; $display("FAIL len0_par: got dout=%02h act=%0b want 5a/0", fif.data_out, fif.pkt_active); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      total++; if (fif.data_out !== 8'h00) begin bad++; $display("FAIL len0_idle: got %02h want 00", fif.data_out); end
      total++; if (fif.data_out !== m_dout || fif.empty !== (model_q.size() == 0)) begin bad++; $display("FAIL pkt_model: got dout=%02h empty=%0b want %02h/%0b", fif.data_out, fif.empty, m_dout, (model_q.size() == 0)); end
   endtask

   task automatic test_soft_reset();
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h0D);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h60 + 8'(i));
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (fif.data_out !== 8'h0D || fif.pkt_active !== 1'b1) begin bad++; $display("FAIL srst_pre: got dout=%02h act=%0b want 0d/1", fif.data_out, fif.pkt_active); end
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h77);
      total++; if (fif.empty !== 1'b1) begin bad++; $display("FAIL srst_empty: got %0b want 1", fif.empty); end
      total++; if (fif.pkt_active !== 1'b0) begin bad++; $display("FAIL srst_active: got %0b want 0", fif.pkt_active); end
      total++; if (fif.data_out !== 8'h00) begin bad++; $display("FAIL srst_dout: got %02h want 00", fif.data_out); end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (fif.empty !== 1'b1 || fif.data_out !== 8'h00) begin bad++; $display("FAIL srst_nowrite: got empty=%0b dout=%02h want 1/00", fif.empty, fif.data_out); end
   endtask

`ifdef ROUTER_FIFO_OCCUPANCY_EN
   task automatic test_occupancy();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h90 + 8'(i));
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++; if (fif.fill_level !== 5'd2) begin bad++; $display("FAIL occ_two: got %0d want 2", fif.fill_level); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      total++; if (fif.fill_level !== 5'd0) begin bad++; $display("FAIL occ_clear: got %0d want 0", fif.fill_level); end
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hC0 + 8'(i));
      total++; if (fif.fill_level !== 5'd16) begin bad++; $display("FAIL occ_full: got %0d want 16", fif.fill_level); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
   endtask
`endif

   initial begin
      fif.write_enb  = 1'b0;
      fif.read_enb   = 1'b0;
      fif.lfd_state  = 1'b0;
      fif.soft_reset = 1'b0;
      fif.data_in    = '0;
      test_reset();
      test_async_reset_midstream();
      test_full_wrap();
      test_simul_rw_full();
      test_packet();
      test_soft_reset();
`ifdef ROUTER_FIFO_OCCUPANCY_EN
      test_occupancy();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
